conv_seq_ctrl: RTL and testbench

Sequencer that drives the 3x3 convolution accelerator's 4-bit register port autonomously, with no CPU involvement.

---
 rtl/conv_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_seq_ctrl.sv
// Autonomous sequencer for the 3x3 convolution accelerator register port: clears it, loads
// nine weights from memory, streams pixels and writes each valid result back to memory.
module conv_seq_ctrl #(
  parameter int unsigned IMG_WIDTH = 128,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [CNT_W-1:0]  num_pixels,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  output logic              acc_en,
  output logic              acc_we,
  output logic [3:0]        acc_addr,
  output logic [31:0]       acc_din,
  input  logic [31:0]       acc_dout
);

  localparam int unsigned SKIP = 2 * IMG_WIDTH + 3;
  localparam logic [CNT_W-1:0] SkipCnt = CNT_W'(SKIP);

  localparam logic [3:0] AccPush = 4'd0;
  localparam logic [3:0] AccReq  = 4'd1;
  localparam logic [3:0] AccClr  = 4'd2;
  localparam logic [3:0] AccW0   = 4'd3;

  typedef enum logic [3:0] {
    StIdle, StClr, StWrd, StWwr, StPrd, StPpush, StPreq, StPwr, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] w_base_q, w_base_d;
  logic [ADDR_W-1:0] src_base_q, src_base_d;
  logic [ADDR_W-1:0] dst_base_q, dst_base_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [3:0]        widx_q, widx_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic [CNT_W-1:0]  k_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      w_base_q   <= '0;
      src_base_q <= '0;
      dst_base_q <= '0;
      num_q      <= '0;
      widx_q     <= '0;
      k_q        <= '0;
    end else begin
      state_q    <= state_d;
      w_base_q   <= w_base_d;
      src_base_q <= src_base_d;
      dst_base_q <= dst_base_d;
      num_q      <= num_d;
      widx_q     <= widx_d;
      k_q        <= k_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    w_base_d    = w_base_q;
    src_base_d  = src_base_q;
    dst_base_d  = dst_base_q;
    num_d       = num_q;
    widx_d      = widx_q;
    k_d         = k_q;
    k_inc       = k_q + CNT_W'(1);
    busy        = 1'b0;
    done        = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    acc_en      = 1'b0;
    acc_we      = 1'b0;
    acc_addr    = '0;
    acc_din     = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          w_base_d   = w_base;
          src_base_d = src_base;
          dst_base_d = dst_base;
          num_d      = num_pixels;
          widx_d     = '0;
          k_d        = '0;
          state_d    = StClr;
        end
      end
      StClr: begin
        acc_en   = 1'b1;
        acc_we   = 1'b1;
        acc_addr = AccClr;
        widx_d   = '0;
        state_d  = StWrd;
      end
      StWrd: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = w_base_q + ADDR_W'(widx_q);
        state_d     = StWwr;
      end
      StWwr: begin
        acc_en   = 1'b1;
        acc_we   = 1'b1;
        acc_addr = AccW0 + widx_q;
        acc_din  = mem_rd_data;
        if (widx_q == 4'd8) begin
          state_d = (num_q == '0) ? StDone : StPrd;
        end else begin
          widx_d  = widx_q + 4'd1;
          state_d = StWrd;
        end
      end
      StPrd: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = src_base_q + ADDR_W'(k_q);
        state_d     = StPpush;
      end
      StPpush: begin
        acc_en   = 1'b1;
        acc_we   = 1'b1;
        acc_addr = AccPush;
        acc_din  = mem_rd_data;
        k_d      = k_inc;
        // The window ending at the final pixel is never read back.
        if (k_inc >= SkipCnt && k_inc != num_q) begin
          state_d = StPreq;
        end else if (k_inc == num_q) begin
          state_d = StDone;
        end else begin
          state_d = StPrd;
        end
      end
      StPreq: begin
        acc_en   = 1'b1;
        acc_addr = AccReq;
        state_d  = StPwr;
      end
      StPwr: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = dst_base_q + ADDR_W'(k_q - SkipCnt);
        mem_wr_data = acc_dout;
        state_d     = (k_q == num_q) ? StDone : StPrd;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort && state_q != StIdle) begin
      state_d = StIdle;
    end

    busy = (state_q != StIdle) && (state_q != StDone);
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl with a word-memory model and a behavioural 3x3 accelerator.
module tb_conv_seq_ctrl;

  localparam int TbW = 4;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] w_base, src_base, dst_base, num_pixels;
  logic        busy, done;
  logic        mem_rd_en, mem_wr_en;
  logic [15:0] mem_rd_addr, mem_wr_addr;
  logic [31:0] mem_rd_data, mem_wr_data;
  logic        acc_en, acc_we;
  logic [3:0]  acc_addr;
  logic [31:0] acc_din, acc_dout;

  int tests = 0;
  int fails = 0;
  int viol = 0;
  int rd_cnt = 0;

  logic [31:0] mem [0:1023];
  logic [47:0] wr_q[$];
  logic [35:0] accw_q[$];
  logic [31:0] acc_w [0:8];
  logic [31:0] acc_pix [0:63];
  int          acc_cnt = 0;

  always #5 clk = ~clk;

  conv_seq_ctrl #(.IMG_WIDTH(TbW), .ADDR_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .w_base(w_base), .src_base(src_base), .dst_base(dst_base), .num_pixels(num_pixels),
    .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .acc_en(acc_en), .acc_we(acc_we), .acc_addr(acc_addr), .acc_din(acc_din),
    .acc_dout(acc_dout)
  );

  wire outs_zero = ({busy, done, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
                     acc_en, acc_we, acc_addr, acc_din} == '0);

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= mem[mem_rd_addr[9:0]];
      rd_cnt <= rd_cnt + 1;
    end
    if (mem_wr_en) wr_q.push_back({mem_wr_addr, mem_wr_data});
    if (acc_en && acc_we) accw_q.push_back({acc_addr, acc_din});
  end

  function automatic logic [31:0] conv_now();
    logic [31:0] s = 0;
    int p = acc_cnt - 1;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        int idx = p - (2 - i) * TbW - (2 - j);
        if (idx >= 0) s = s + acc_w[3 * i + j] * acc_pix[idx[5:0]];
      end
    end
    return s;
  endfunction

  // Stand-in accelerator: push, registered read of the current window, clear, weights.
  always @(posedge clk) begin
    if (acc_en && acc_we) begin
      if (acc_addr == 4'd0) begin
        acc_pix[acc_cnt[5:0]] <= acc_din;
        acc_cnt <= acc_cnt + 1;
      end else if (acc_addr == 4'd2) begin
        acc_cnt <= 0;
      end else if (acc_addr >= 4'd3 && acc_addr <= 4'd11) begin
        acc_w[acc_addr - 4'd3] <= acc_din;
      end
    end else if (acc_en && acc_addr == 4'd1) begin
      acc_dout <= conv_now();
    end
  end

  always @(negedge clk) begin
    if ((mem_rd_en && mem_wr_en) || (acc_we && !acc_en)) viol <= viol + 1;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, observed hang expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [15:0] wb, input logic [15:0] sb, input logic [15:0] db,
                         input logic [15:0] n);
    w_base = wb; src_base = sb; dst_base = db; num_pixels = n;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycle i is the i-th cycle after the start-sampling edge; cyc=0 means done never seen.
  task automatic wait_done(input int limit, output int cyc, output int bcnt);
    cyc = 0;
    bcnt = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic check_results(input string tag, input int first, input int step,
                               input int n);
    logic [47:0] e;
    check({tag, "_nwr"}, wr_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < wr_q.size()) begin
        e = wr_q[i];
        check({tag, "_addr"}, e[47:32], 32'h200 + i);
        check({tag, "_data"}, e[31:0], first + step * i);
      end
    end
  endtask

  task automatic run_full(input string tag, input int n, input int exp_cyc);
    int cyc, bc;
    wr_q.delete();
    set_cfg(16'h0, 16'h100, 16'h200, n[15:0]);
    pulse_start();
    wait_done(400, cyc, bc);
    check({tag, "_cyc"}, cyc, exp_cyc);
    check({tag, "_busy"}, bc, exp_cyc - 1);
  endtask

  initial begin
    int cyc, bc, n, rd0, strobes, dones;
    logic [35:0] aw;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 9; i++) mem[i] = 32'd1;
    for (int i = 0; i < 16; i++) mem[16'h100 + i] = i + 1;
    for (int i = 0; i < 9; i++) mem[16'h40 + i] = 32'h10 + i;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    set_cfg(16'h0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    check("reset_outs_zero", outs_zero, 1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Scenario 1: all-ones weights, pixels 1..16, SKIP=11 -> M=5 results.
    run_full("t1", 16, 62);
    check_results("t1", 54, 9, 5);

    // Scenario 2: N=0 only clears and loads weights.
    wr_q.delete();
    accw_q.delete();
    rd0 = rd_cnt;
    set_cfg(16'h40, 16'h100, 16'h200, 16'h0);
    pulse_start();
    wait_done(400, cyc, bc);
    check("t2_cyc", cyc, 20);
    check("t2_busy", bc, 19);
    check("t2_nwr", wr_q.size(), 0);
    check("t2_nrd", rd_cnt - rd0, 9);
    check("t2_nacc", accw_q.size(), 10);
    if (accw_q.size() == 10) begin
      check("t2_clr", accw_q[0], {4'd2, 32'd0});
      for (int i = 0; i < 9; i++) begin
        aw = accw_q[i + 1];
        check("t2_waddr", aw[35:32], 3 + i);
        check("t2_wdata", aw[31:0], 32'h10 + i);
      end
    end

    // Scenario 3: counts straddling SKIP.
    run_full("t3_n12", 12, 46);
    check_results("t3_n12", 54, 9, 1);
    run_full("t3_n11", 11, 42);
    check("t3_n11_nwr", wr_q.size(), 0);
    run_full("t3_n10", 10, 40);
    check("t3_n10_nwr", wr_q.size(), 0);

    // Scenario 4: abort during the third result write, then rerun.
    wr_q.delete();
    set_cfg(16'h0, 16'h100, 16'h200, 16'd16);
    pulse_start();
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_wr_en) n++;
      if (n == 3) break;
    end
    check("t4_reached_pwr3", n, 3);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("t4_busy_low", busy, 0);
    strobes = 0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_rd_en || mem_wr_en || acc_en) strobes++;
      if (done) dones++;
      @(negedge clk);
    end
    check("t4_no_strobes", strobes, 0);
    check("t4_no_done", dones, 0);
    check_results("t4_abort", 54, 9, 3);
    run_full("t4_rerun", 16, 62);
    check_results("t4_rerun", 54, 9, 5);

    // Scenario 5a: a second start while busy is ignored.
    wr_q.delete();
    set_cfg(16'h0, 16'h100, 16'h200, 16'd16);
    pulse_start();
    repeat (25) @(negedge clk);
    set_cfg(16'h40, 16'h0, 16'h300, 16'd3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(400, cyc, bc);
    check("t5_cyc", cyc, 36);
    check_results("t5", 54, 9, 5);

    // Scenario 5b: reset mid pixel stream.
    set_cfg(16'h0, 16'h100, 16'h200, 16'd16);
    pulse_start();
    repeat (30) @(negedge clk);
    check("t5_busy_mid", busy, 1);
    rst = 1'b1;
    #1 check("t5_rst_async", outs_zero, 1);
    @(negedge clk);
    check("t5_rst_hold", outs_zero, 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_rst_idle", outs_zero, 1);

    // Scenario 6: centre-only weight of 2 over ramp 3*i+7.
    for (int i = 0; i < 9; i++) mem[16'h40 + i] = (i == 4) ? 32'd2 : 32'd0;
    for (int i = 0; i < 16; i++) mem[16'h100 + i] = 3 * i + 7;
    wr_q.delete();
    set_cfg(16'h40, 16'h100, 16'h200, 16'd16);
    pulse_start();
    wait_done(400, cyc, bc);
    check("t6_cyc", cyc, 62);
    check_results("t6", 44, 6, 5);

    check("strobe_exclusivity", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
